// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding, default depth
// and requester port indices.
package dmem_pkg;

   typedef enum logic {
      ARB    = 1'b0,
      LOCKED = 1'b1
   } state_t;

   localparam int DEPTH_DEFAULT = 1024;
   localparam int P_CORE        = 0;
   localparam int P_DMA         = 1;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin grant. Purely combinational; the pointer register
// lives with the caller, which is told via upd when a contested grant happened.
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       ptr,
   input  logic       en,
   output logic [1:0] gnt,
   output logic       upd
);

   always_comb begin
      gnt = 2'b00;
      if (en) begin
         if (req == 2'b11)
            gnt = ptr ? 2'b10 : 2'b01;
         else
            gnt = req;
      end
   end

   // Pointer only moves when both ports competed for this cycle.
   assign upd = en & (&req);

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data memory between the core LSU and the DMA/loader port with
// round-robin arbitration, an atomic lock, and a one-cycle registered response.
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int DEPTH  = DEPTH_DEFAULT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [1:0]        req_valid,
   output logic [1:0]        req_ready,
   input  logic [1:0]        req_we,
   input  logic [1:0]        req_lock,
   input  logic [ADDR_W-1:0] req_addr0,
   input  logic [ADDR_W-1:0] req_addr1,
   input  logic [DATA_W-1:0] req_wdata0,
   input  logic [DATA_W-1:0] req_wdata1,
   output logic [1:0]        rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wd,
   output logic              mem_we,
   input  logic [DATA_W-1:0] mem_rd
);

   state_t              state;
   logic                rr_ptr;
   logic                lock_owner;

   logic [1:0]          rr_gnt;
   logic                rr_upd;
   logic [1:0]          gnt;
   logic                sel;
   logic                hs;
   logic                sel_we;
   logic                sel_lock;
   logic                in_range;
   logic [ADDR_W-1:0]   sel_addr;
   logic [DATA_W-1:0]   sel_wdata;

   logic [1:0]          vld_p1;
   logic [DATA_W-1:0]   rdata_p1;
   logic                err_p1;

   rr_arb2 u_rr (
      .req (req_valid),
      .ptr (rr_ptr),
      .en  (state == ARB),
      .gnt (rr_gnt),
      .upd (rr_upd)
   );

   // While locked, the round-robin result is ignored and only the owner may win.
   always_comb begin
      gnt = rr_gnt;
      if (state == LOCKED) begin
         gnt             = 2'b00;
         gnt[lock_owner] = req_valid[lock_owner];
      end
   end

   assign req_ready = gnt;
   assign hs        = |gnt;
   assign sel       = gnt[P_DMA];
   assign sel_addr  = sel ? req_addr1  : req_addr0;
   assign sel_wdata = sel ? req_wdata1 : req_wdata0;
   assign sel_we    = req_we[sel];
   assign sel_lock  = req_lock[sel];
   assign in_range  = sel_addr < ADDR_W'(DEPTH);

   // Memory pins are zeroed when idle so the bus is quiet without a grant.
   assign mem_addr = hs ? sel_addr  : '0;
   assign mem_wd   = hs ? sel_wdata : '0;
   assign mem_we   = hs & sel_we & in_range;

   // ---- stage p0 -> p1: grant bookkeeping and registered response ----
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ARB;
         rr_ptr     <= 1'b0;
         lock_owner <= 1'b0;
         vld_p1     <= 2'b00;
         rdata_p1   <= '0;
         err_p1     <= 1'b0;
      end else begin
         vld_p1   <= gnt;
         rdata_p1 <= (hs && !sel_we && in_range) ? mem_rd : '0;
         err_p1   <= hs & ~in_range;
         case (state)
            ARB: begin
               if (rr_upd)
                  rr_ptr <= ~sel;
               if (hs && sel_lock) begin
                  state      <= LOCKED;
                  lock_owner <= sel;
               end
            end
            LOCKED: begin
               if (hs && !sel_lock) begin
                  state  <= ARB;
                  rr_ptr <= ~lock_owner;
               end
            end
            default: state <= ARB;
         endcase
      end
   end

   assign rsp_valid = vld_p1;
   assign rsp_rdata = rdata_p1;
   assign rsp_err   = err_p1;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed and randomized bench for dmem_arbiter against an abstract model of
// grant order, lock ownership and memory contents.
module tb_dmem_arbiter;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int DEPTH  = 1024;

   logic              clk = 1'b0;
   logic              reset;
   logic [1:0]        req_valid;
   logic [1:0]        req_ready;
   logic [1:0]        req_we;
   logic [1:0]        req_lock;
   logic [ADDR_W-1:0] req_addr0;
   logic [ADDR_W-1:0] req_addr1;
   logic [DATA_W-1:0] req_wdata0;
   logic [DATA_W-1:0] req_wdata1;
   logic [1:0]        rsp_valid;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wd;
   logic              mem_we;
   logic [DATA_W-1:0] mem_rd;

   int checks   = 0;
   int failures = 0;

   bit          m_locked;
   int          m_owner;
   int          m_pref;
   logic [31:0] ref_mem [0:DEPTH-1];

   always #5 clk = ~clk;

   dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_lock   (req_lock),
      .req_addr0  (req_addr0),
      .req_addr1  (req_addr1),
      .req_wdata0 (req_wdata0),
      .req_wdata1 (req_wdata1),
      .rsp_valid  (rsp_valid),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err),
      .mem_addr   (mem_addr),
      .mem_wd     (mem_wd),
      .mem_we     (mem_we),
      .mem_rd     (mem_rd)
   );

   // Behavioural data memory: combinational read, 0 while writing.
   logic [31:0] mem [0:DEPTH-1];
   always @(posedge clk) if (mem_we) mem[mem_addr[9:0]] <= mem_wd;
   assign mem_rd = mem_we ? '0 : ((mem_addr < DEPTH) ? mem[mem_addr[9:0]] : '0);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // One clock of stimulus: checks the same-cycle grant/memory drive and the
   // response that follows the edge, advancing the model alongside.
   task automatic cyc(input logic [1:0] v, input logic [1:0] we, input logic [1:0] lk,
                      input logic [31:0] a0, input logic [31:0] a1,
                      input logic [31:0] d0, input logic [31:0] d1, input bit rst);
      int          g;
      logic [31:0] a, d, e_rdy, e_rd;
      bit          inr, e_err, e_we;
      @(negedge clk);
      reset = rst; req_valid = v; req_we = we; req_lock = lk;
      req_addr0 = a0; req_addr1 = a1; req_wdata0 = d0; req_wdata1 = d1;
      g = -1;
      if (m_locked) begin
         if (v[m_owner]) g = m_owner;
      end else if (v == 2'b11) g = m_pref;
      else if (v[0]) g = 0;
      else if (v[1]) g = 1;
      a     = (g == 1) ? a1 : a0;
      d     = (g == 1) ? d1 : d0;
      inr   = (a < DEPTH);
      e_rdy = (g < 0) ? 32'd0 : (32'd1 << g);
      e_we  = (g >= 0) && we[g] && inr;
      #1;
      chk("req_ready", {30'd0, req_ready}, e_rdy);
      chk("mem_addr", mem_addr, (g < 0) ? 32'd0 : a);
      chk("mem_wd", mem_wd, (g < 0) ? 32'd0 : d);
      chk("mem_we", {31'd0, mem_we}, {31'd0, e_we});
      e_rd  = ((g >= 0) && !we[g] && inr) ? ref_mem[a[9:0]] : 32'd0;
      e_err = (g >= 0) && !inr;
      if (e_we) ref_mem[a[9:0]] = d;
      if (rst) begin
         m_locked = 0; m_owner = 0; m_pref = 0;
         e_rdy = 0; e_rd = 0; e_err = 0;
      end else if (g >= 0) begin
         if (!m_locked) begin
            if (v == 2'b11) m_pref = 1 - g;
            if (lk[g]) begin m_locked = 1; m_owner = g; end
         end else if (!lk[g]) begin
            m_locked = 0; m_pref = 1 - m_owner;
         end
      end
      @(posedge clk);
      #1;
      chk("rsp_valid", {30'd0, rsp_valid}, e_rdy);
      chk("rsp_rdata", rsp_rdata, e_rd);
      chk("rsp_err", {31'd0, rsp_err}, {31'd0, e_err});
   endtask

   function automatic logic [31:0] rand_addr();
      int r;
      r = $urandom_range(0, 9);
      if (r == 0) return 32'd1024 + $urandom_range(0, 7);
      if (r == 1) return 32'hFFFF_FFF0 + $urandom_range(0, 15);
      return $urandom_range(0, 15);
   endfunction

   initial begin
      reset = 1'b1; req_valid = 0; req_we = 0; req_lock = 0;
      req_addr0 = 0; req_addr1 = 0; req_wdata0 = 0; req_wdata1 = 0;
      m_locked = 0; m_owner = 0; m_pref = 0;
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'd0;

      cyc(2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 1'b1);
      cyc(2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 1'b1);
      cyc(2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 1'b0);

      // Single write then readback on port 0.
      cyc(2'b01, 2'b01, 2'b00, 5, 0, 32'hDEADBEEF, 0, 1'b0);
      chk("t1_wr_rsp", {30'd0, rsp_valid}, 32'd1);
      cyc(2'b01, 2'b00, 2'b00, 5, 0, 0, 0, 1'b0);
      chk("t1_rd_data", rsp_rdata, 32'hDEADBEEF);

      // Preload low addresses back-to-back from port 1.
      for (int i = 0; i < 16; i++)
         cyc(2'b10, 2'b10, 2'b00, 0, i, 0,
             (i == 1) ? 32'h11 : (i == 2) ? 32'h22 : $urandom, 1'b0);

      // Contested reads alternate starting at port 0 after reset.
      cyc(2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 1'b1);
      for (int k = 0; k < 4; k++) begin
         cyc(2'b11, 2'b00, 2'b00, 1, 2, 0, 0, 1'b0);
         chk("t2_rsp_valid", {30'd0, rsp_valid}, (k % 2 == 0) ? 32'd1 : 32'd2);
         chk("t2_rdata", rsp_rdata, (k % 2 == 0) ? 32'h11 : 32'h22);
      end

      // Port 1 locks over a read/write pair while port 0 keeps requesting.
      cyc(2'b11, 2'b00, 2'b00, 1, 2, 0, 0, 1'b0);
      cyc(2'b11, 2'b00, 2'b10, 3, 7, 0, 0, 1'b0);
      chk("t3_lock_rd", {30'd0, rsp_valid}, 32'd2);
      cyc(2'b11, 2'b10, 2'b00, 3, 7, 0, 32'hCAFE0007, 1'b0);
      chk("t3_lock_wr", {30'd0, rsp_valid}, 32'd2);
      cyc(2'b11, 2'b00, 2'b00, 3, 7, 0, 0, 1'b0);
      chk("t3_after", {30'd0, rsp_valid}, 32'd1);
      cyc(2'b10, 2'b00, 2'b00, 0, 7, 0, 0, 1'b0);
      chk("t3_wr_landed", rsp_rdata, 32'hCAFE0007);

      // Out-of-range write at DEPTH, then address 0 unchanged.
      cyc(2'b01, 2'b01, 2'b00, 1024, 0, 32'h1, 0, 1'b0);
      chk("t4_err", {31'd0, rsp_err}, 32'd1);
      cyc(2'b01, 2'b00, 2'b00, 0, 0, 0, 0, 1'b0);

      // Reset while locked with an access in flight.
      cyc(2'b10, 2'b00, 2'b10, 0, 3, 0, 0, 1'b0);
      cyc(2'b11, 2'b00, 2'b10, 4, 3, 0, 0, 1'b1);
      chk("t5_rsp_cleared", {30'd0, rsp_valid}, 32'd0);
      cyc(2'b11, 2'b00, 2'b00, 4, 3, 0, 0, 1'b0);
      chk("t5_port0_first", {30'd0, rsp_valid}, 32'd1);

      // Port 1 streams four reads with port 0 idle.
      for (int i = 8; i < 12; i++) begin
         cyc(2'b10, 2'b00, 2'b00, 0, i, 0, 0, 1'b0);
         chk("t6_stream", {30'd0, rsp_valid}, 32'd2);
      end

      // Randomized traffic including locks, out-of-range and rare resets.
      for (int n = 0; n < 400; n++)
         cyc(2'($urandom), 2'($urandom),
             ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00,
             rand_addr(), rand_addr(), $urandom, $urandom,
             ($urandom_range(0, 63) == 0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
